// File: rtl/add_serial_param_if.sv
// add_serial_param_if: start/done handshake and operand/result bundle for
// the parametrised serial adder. The ovf signal only exists when the design
// is built with ADD_SERIAL_OVF_EN defined.
interface add_serial_param_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] out;
    logic             cout;
    logic             busy;
    logic             done;
`ifdef ADD_SERIAL_OVF_EN
    logic             ovf;

    modport master (
        output start, sub, a, b,
        input  out, cout, busy, done, ovf
    );

    modport slave (
        input  start, sub, a, b,
        output out, cout, busy, done, ovf
    );
`else
    modport master (
        output start, sub, a, b,
        input  out, cout, busy, done
    );

    modport slave (
        input  start, sub, a, b,
        output out, cout, busy, done
    );
`endif
endinterface

// File: rtl/add_serial_param.sv
// add_serial_param: digit-serial adder/subtractor, WIDTH bits processed
// DIGIT bits per clock (STEPS = WIDTH/DIGIT cycles per operation).
// Subtraction is a + ~b + 1, so cout=1 means "no borrow".
// Optional macro ADD_SERIAL_OVF_EN adds a registered two's-complement
// overflow flag (bus.ovf); without it the flag and its logic are absent.
module add_serial_param #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    add_serial_param_if.slave    bus
);
    localparam int STEPS = WIDTH / DIGIT;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] out_reg;
    logic             carry;
    logic             cout_reg;
    logic [CNT_W-1:0] count;
    logic [DIGIT:0]   sum;
    logic [WIDTH-1:0] out_next;

    // Digit adder: low digit of both operands plus the running carry.
    always_comb begin
        sum = {1'b0, a_reg[DIGIT-1:0]} + {1'b0, b_reg[DIGIT-1:0]}
            + {{DIGIT{1'b0}}, carry};
    end

    // New digits enter at the top of out, so after STEPS shifts the first
    // digit has reached bit 0; a single-digit word is simply replaced.
    generate
        if (DIGIT == WIDTH) begin : g_full
            always_comb begin
                out_next = sum[DIGIT-1:0];
            end
        end else begin : g_shift
            always_comb begin
                out_next = {sum[DIGIT-1:0], out_reg[WIDTH-1:DIGIT]};
            end
        end
    endgenerate

`ifdef ADD_SERIAL_OVF_EN
    logic ovf_reg;
    logic carry_msb;

    // Carry into the word MSB: the MSB is the top bit of the last digit, so
    // it is the carry out of that digit's lower DIGIT-1 bits.
    generate
        if (DIGIT == 1) begin : g_msb_direct
            always_comb begin
                carry_msb = carry;
            end
        end else begin : g_msb_partial
            logic [DIGIT-1:0] low_sum;
            always_comb begin
                low_sum = {1'b0, a_reg[DIGIT-2:0]} + {1'b0, b_reg[DIGIT-2:0]}
                        + {{(DIGIT-1){1'b0}}, carry};
                carry_msb = low_sum[DIGIT-1];
            end
        end
    endgenerate

    assign bus.ovf = ovf_reg;
`endif

    // Control FSM and datapath: capture in IDLE/DONE, one digit per cycle in
    // ADD, results frozen in DONE until the next start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            a_reg    <= '0;
            b_reg    <= '0;
            out_reg  <= '0;
            carry    <= 1'b0;
            cout_reg <= 1'b0;
            count    <= '0;
`ifdef ADD_SERIAL_OVF_EN
            ovf_reg  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        a_reg    <= bus.a;
                        b_reg    <= bus.sub ? ~bus.b : bus.b;
                        carry    <= bus.sub;
                        count    <= '0;
                        out_reg  <= '0;
                        cout_reg <= 1'b0;
`ifdef ADD_SERIAL_OVF_EN
                        ovf_reg  <= 1'b0;
`endif
                        state    <= ADD;
                    end
                end
                ADD: begin
                    out_reg <= out_next;
                    carry   <= sum[DIGIT];
                    a_reg   <= a_reg >> DIGIT;
                    b_reg   <= b_reg >> DIGIT;
                    count   <= count + CNT_W'(1);
                    if (count == LAST_STEP) begin
                        state    <= DONE;
                        cout_reg <= sum[DIGIT];
`ifdef ADD_SERIAL_OVF_EN
                        ovf_reg  <= carry_msb ^ sum[DIGIT];
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.out  = out_reg;
    assign bus.cout = cout_reg;
    assign bus.busy = (state == ADD);
    assign bus.done = (state == DONE);
endmodule
